// File: rtl/sram_window_controller_if.sv
// MSX slot bus (cartridge side) and host RAM port bundles
// shared by the SRAM window controller.
interface BUS_IF;
    logic [15:0] ADDR;
    logic [7:0]  DIN;
    logic [7:0]  DOUT;
    logic        SLTSL_n;
    logic        MERQ_n;
    logic        RD_n;
    logic        WR_n;
    logic        RFSH_n;
    logic        RESET_n;
    logic        BUSDIR_n;
    logic        INT_n;
    logic        WAIT_n;

    modport CARTRIDGE (
        input  ADDR, DIN, SLTSL_n, MERQ_n, RD_n, WR_n, RFSH_n, RESET_n,
        output DOUT, BUSDIR_n, INT_n, WAIT_n
    );
endinterface

interface RAM_IF;
    logic [23:0] ADDR;
    logic [15:0] DIN;
    logic [7:0]  DOUT;
    logic [4:0]  DIN_SIZE;
    logic        WE_n;
    logic        OE_n;
    logic        RFSH_n;

    modport HOST (
        output ADDR, DIN, DIN_SIZE, WE_n, OE_n, RFSH_n,
        input  DOUT
    );
endinterface

// File: rtl/sram_window_controller.sv
// MSX cartridge: BIOS ROM at 4000-7FFF with a keyed, paged SRAM window
// and a save sequencer that requests a backup after write silence.
module sram_window_controller #(
    parameter logic [23:0] RAM_ADDR_BIOS = 24'h000000,
    parameter logic [23:0] RAM_ADDR_SRAM = 24'h000000,
    parameter int          WIN_BITS      = 13,
    parameter int          PAGE_COUNT    = 1,
    parameter logic [15:0] KEY           = 16'h694D,
    parameter logic [15:0] PAGE_ADDR     = 16'h7FF7,
    parameter int          SAVE_DELAY    = 1000000
) (
    input  logic     CLK,
    input  logic     RESET_n,
    BUS_IF.CARTRIDGE Bus,
    RAM_IF.HOST      Ram,
    output logic     UNLOCKED,
    output logic     DIRTY,
    output logic     SAVE_REQ,
    input  logic     SAVE_ACK
);
    localparam int PB = (PAGE_COUNT > 1) ? $clog2(PAGE_COUNT) : 0;
    localparam int PW = (PB > 0) ? PB : 1;
    localparam logic [13:0] WIN_MASK = 14'((1 << WIN_BITS) - 1);

    typedef enum logic [1:0] {CLEAN, COUNT, REQ, REQ_RD} save_t;

    logic          w_wr, w_rd, w_cs, w_det_wr, w_unl, w_in_win;
    logic          w_reg_adr, w_sram_wr, w_read, w_evt;
    logic [23:0]   w_sram_addr, w_ram_addr;
    logic          r_wr, r_unlocked;
    logic [7:0]    r_key_lo, r_key_hi;
    logic [PW-1:0] r_page;
    logic          r_we_n, r_oe_n, r_busdir_n, r_rfsh_n;
    logic [23:0]   r_addr;
    logic [15:0]   r_din;
    logic [7:0]    r_dout;
    save_t         r_state, w_state_nx;
    logic [31:0]   r_cnt, w_cnt_nx;
    logic          r_dirty, r_save_req;

    assign w_wr     = !Bus.SLTSL_n && !Bus.MERQ_n && !Bus.WR_n;
    assign w_rd     = !Bus.SLTSL_n && !Bus.MERQ_n && !Bus.RD_n;
    assign w_cs     = Bus.ADDR[15:14] == 2'b01;
    assign w_det_wr = w_wr && !r_wr;
    assign w_unl    = {r_key_hi, r_key_lo} == KEY;
    assign w_in_win = w_cs && w_unl
                      && ((Bus.ADDR[13:0] & ~WIN_MASK) == 14'd0);
    assign w_reg_adr = (Bus.ADDR == 16'h5FFE) || (Bus.ADDR == 16'h5FFF)
                       || (Bus.ADDR == PAGE_ADDR);
    assign w_sram_wr = w_in_win && w_wr && !w_reg_adr;
    assign w_read    = w_cs && w_rd;
    assign w_evt     = w_det_wr && w_sram_wr;

    assign w_sram_addr = RAM_ADDR_SRAM + ((24'(r_page) << WIN_BITS)
                         | {10'd0, Bus.ADDR[13:0] & WIN_MASK});
    assign w_ram_addr  = w_in_win ? w_sram_addr
                         : {RAM_ADDR_BIOS[23:14], Bus.ADDR[13:0]};

    // Soft bus reset clears mapping and idles the ports, never the save state.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_wr       <= 1'b0;
            r_unlocked <= 1'b0;
            r_key_lo   <= 8'h00;
            r_key_hi   <= 8'h00;
            r_page     <= '0;
            r_we_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_busdir_n <= 1'b1;
            r_rfsh_n   <= 1'b1;
            r_addr     <= 24'd0;
            r_din      <= 16'd0;
            r_dout     <= 8'h00;
        end else begin
            r_wr       <= w_wr;
            r_unlocked <= w_unl;
            if (!Bus.RESET_n) begin
                r_key_lo   <= 8'h00;
                r_key_hi   <= 8'h00;
                r_page     <= '0;
                r_we_n     <= 1'b1;
                r_oe_n     <= 1'b1;
                r_busdir_n <= 1'b1;
                r_rfsh_n   <= 1'b1;
                r_addr     <= 24'd0;
                r_din      <= 16'd0;
                r_dout     <= 8'h00;
            end else begin
                if (w_det_wr && Bus.ADDR == 16'h5FFE)
                    r_key_lo <= Bus.DIN;
                if (w_det_wr && Bus.ADDR == 16'h5FFF)
                    r_key_hi <= Bus.DIN;
                if (PB > 0 && w_det_wr && Bus.ADDR == PAGE_ADDR)
                    r_page <= Bus.DIN[PW-1:0];
                r_we_n     <= !w_sram_wr;
                r_oe_n     <= !w_read;
                r_busdir_n <= !w_read;
                r_rfsh_n   <= Bus.RFSH_n;
                r_addr     <= (w_read || w_sram_wr) ? w_ram_addr : 24'd0;
                r_din      <= w_sram_wr ? {8'h00, Bus.DIN} : 16'd0;
                r_dout     <= w_read ? Ram.DOUT : 8'h00;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            CLEAN: begin
                if (w_evt) begin
                    w_state_nx = COUNT;
                    w_cnt_nx   = 32'd0;
                end
            end
            COUNT: begin
                if (w_evt)
                    w_cnt_nx = 32'd0;
                else if (r_cnt == 32'(SAVE_DELAY - 1))
                    w_state_nx = REQ;
                else
                    w_cnt_nx = r_cnt + 32'd1;
            end
            REQ: begin
                // A write racing the ack means the backup is already stale.
                if (w_evt && SAVE_ACK) begin
                    w_state_nx = COUNT;
                    w_cnt_nx   = 32'd0;
                end else if (w_evt) begin
                    w_state_nx = REQ_RD;
                end else if (SAVE_ACK) begin
                    w_state_nx = CLEAN;
                end
            end
            REQ_RD: begin
                if (SAVE_ACK) begin
                    w_state_nx = COUNT;
                    w_cnt_nx   = 32'd0;
                end
            end
            default: w_state_nx = CLEAN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state    <= CLEAN;
            r_cnt      <= 32'd0;
            r_dirty    <= 1'b0;
            r_save_req <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_dirty    <= r_state != CLEAN;
            r_save_req <= (r_state == REQ) || (r_state == REQ_RD);
        end
    end

    assign Ram.ADDR     = r_addr;
    assign Ram.DIN      = r_din;
    assign Ram.DIN_SIZE = 5'd8;
    assign Ram.WE_n     = r_we_n;
    assign Ram.OE_n     = r_oe_n;
    assign Ram.RFSH_n   = r_rfsh_n;
    assign Bus.DOUT     = r_dout;
    assign Bus.BUSDIR_n = r_busdir_n;
    assign Bus.INT_n    = 1'b1;
    assign Bus.WAIT_n   = 1'b1;
    assign UNLOCKED     = r_unlocked;
    assign DIRTY        = r_dirty;
    assign SAVE_REQ     = r_save_req;
endmodule

// File: tb/tb_sram_window_controller.sv
// Bench for sram_window_controller: RAM-port scoreboard plus
// directed checks of key, paging and save sequencing.
module tb_sram_window_controller;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ack = 1'b0;
    logic       unlocked, dirty, save_req;
    logic [7:0] rbyte = 8'h00;
    int         total = 0;
    int         bad = 0;
    logic       prev_we = 1'b1;
    logic       prev_oe = 1'b1;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  data;
    } acc_t;
    acc_t sb[$];

    BUS_IF bus();
    RAM_IF ram();
    assign ram.DOUT = rbyte;

    sram_window_controller #(
        .RAM_ADDR_BIOS(24'h020000),
        .RAM_ADDR_SRAM(24'h100000),
        .WIN_BITS(13),
        .PAGE_COUNT(4),
        .KEY(16'h694D),
        .PAGE_ADDR(16'h7FF7),
        .SAVE_DELAY(16)
    ) dut (
        .CLK(clk),
        .RESET_n(rst_n),
        .Bus(bus),
        .Ram(ram),
        .UNLOCKED(unlocked),
        .DIRTY(dirty),
        .SAVE_REQ(save_req),
        .SAVE_ACK(ack)
    );

    always #5 clk = ~clk;

    task automatic sb_check(input logic we);
        acc_t e;
        logic [7:0] d;
        logic side_bad;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected we=%0b addr=%06h", we, ram.ADDR);
            return;
        end
        e = sb.pop_front();
        d = we ? ram.DIN[7:0] : bus.DOUT;
        side_bad = we ? (ram.DIN[15:8] !== 8'h00) : (bus.BUSDIR_n !== 1'b0);
        if (e.we !== we || e.addr !== ram.ADDR || e.data !== d || side_bad) begin
            bad++;
            $display("FAIL sb_access got we=%0b addr=%06h data=%02h exp we=%0b addr=%06h data=%02h",
                     we, ram.ADDR, d, e.we, e.addr, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (prev_we && !ram.WE_n) sb_check(1'b1);
        if (prev_oe && !ram.OE_n) sb_check(1'b0);
        prev_we = ram.WE_n;
        prev_oe = ram.OE_n;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.SLTSL_n = 1'b1;
        bus.MERQ_n  = 1'b1;
        bus.RD_n    = 1'b1;
        bus.WR_n    = 1'b1;
        bus.ADDR    = 16'h0000;
        bus.DIN     = 8'h00;
    endtask

    task automatic start_write(input logic [15:0] a, input logic [7:0] d);
        bus.ADDR    = a;
        bus.DIN     = d;
        bus.SLTSL_n = 1'b0;
        bus.MERQ_n  = 1'b0;
        bus.WR_n    = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        tick();
        start_write(a, d);
        repeat (3) tick();
        bus_idle();
        repeat (2) tick();
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [7:0] b);
        rbyte = b;
        tick();
        bus.ADDR    = a;
        bus.SLTSL_n = 1'b0;
        bus.MERQ_n  = 1'b0;
        bus.RD_n    = 1'b0;
        repeat (3) tick();
        bus_idle();
        repeat (2) tick();
    endtask

    task automatic push(input logic we, input logic [23:0] a, input logic [7:0] d);
        sb.push_back({we, a, d});
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!save_req && n < 60) begin
            tick();
            n++;
        end
        chk(nm, 32'(save_req), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) begin
            int n = 0;
            while (!save_req && n < 60) begin
                tick();
                n++;
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            tick();
            if (!dirty) break;
        end
        chk("drain_clean", 32'(dirty), 32'd0);
    endtask

    initial begin
        bus_idle();
        bus.RESET_n = 1'b1;
        bus.RFSH_n  = 1'b0;
        #12;
        chk("rst_we_oe", {ram.WE_n, ram.OE_n}, 2'b11);
        chk("rst_addr_din", {ram.ADDR, ram.DIN}, 40'd0);
        chk("rst_din_size", 32'(ram.DIN_SIZE), 32'd8);
        chk("rst_rfsh", 32'(ram.RFSH_n), 32'd1);
        chk("rst_bus", {bus.DOUT, bus.BUSDIR_n, bus.INT_n, bus.WAIT_n}, 11'h007);
        chk("rst_flags", {unlocked, dirty, save_req}, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rfsh_low", 32'(ram.RFSH_n), 32'd0);
        bus.RFSH_n = 1'b1;
        tick();
        chk("rfsh_high", 32'(ram.RFSH_n), 32'd1);

        // Locked: BIOS reads, window writes ignored
        push(1'b0, 24'h020123, 8'h3C);
        bus_read(16'h4123, 8'h3C);
        chk("dout_idle", 32'(bus.DOUT), 32'd0);
        bus_write(16'h4010, 8'h77);
        bus_read(16'h8000, 8'h11);
        chk("locked_clean", 32'(dirty), 32'd0);
        chk("locked_flag", 32'(unlocked), 32'd0);

        // Unlock and SRAM access
        bus_write(16'h5FFE, 8'h4D);
        bus_write(16'h5FFF, 8'h69);
        chk("unlock", 32'(unlocked), 32'd1);
        push(1'b1, 24'h100010, 8'hA5);
        bus_write(16'h4010, 8'hA5);
        chk("dirty_set", 32'(dirty), 32'd1);
        push(1'b0, 24'h100010, 8'h5E);
        bus_read(16'h4010, 8'h5E);
        push(1'b0, 24'h022000, 8'hC3);
        bus_read(16'h6000, 8'hC3);
        push(1'b1, 24'h101FFD, 8'h81);
        bus_write(16'h5FFD, 8'h81);
        bus_write(16'h6000, 8'h99);
        bus_write(16'h5FFE, 8'h00);
        chk("relock", 32'(unlocked), 32'd0);
        bus_write(16'h4010, 8'h77);
        push(1'b0, 24'h020010, 8'h42);
        bus_read(16'h4010, 8'h42);
        drain();

        // Paging
        bus_write(16'h5FFE, 8'h4D);
        bus_write(16'h5FFF, 8'h69);
        bus_write(16'h7FF7, 8'h02);
        push(1'b1, 24'h104001, 8'h5A);
        bus_write(16'h4001, 8'h5A);
        bus_write(16'h7FF7, 8'h03);
        push(1'b1, 24'h107FFD, 8'h11);
        bus_write(16'h5FFD, 8'h11);
        bus_write(16'h7FF7, 8'h06);
        push(1'b1, 24'h104000, 8'h22);
        bus_write(16'h4000, 8'h22);
        drain();

        // Save delay timing from the write edge
        push(1'b1, 24'h104020, 8'h12);
        start_write(16'h4020, 8'h12);
        repeat (3) tick();
        bus_idle();
        repeat (14) tick();
        chk("t4_req_early", 32'(save_req), 32'd0);
        tick();
        chk("t4_req_rise", 32'(save_req), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("t4_ack", {dirty, save_req}, 2'b00);

        // Stray ack in COUNT, write during REQ, write racing ack
        push(1'b1, 24'h104030, 8'h34);
        start_write(16'h4030, 8'h34);
        repeat (3) tick();
        bus_idle();
        repeat (2) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (11) tick();
        chk("t5_req_early", 32'(save_req), 32'd0);
        tick();
        chk("t5_req_rise", 32'(save_req), 32'd1);
        push(1'b1, 24'h104031, 8'h56);
        bus_write(16'h4031, 8'h56);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("t5_rd_ack", {dirty, save_req}, 2'b10);
        repeat (15) tick();
        chk("t5_rereq_early", 32'(save_req), 32'd0);
        tick();
        chk("t5_rereq", 32'(save_req), 32'd1);
        push(1'b1, 24'h104032, 8'h78);
        start_write(16'h4032, 8'h78);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk("t5_race", {dirty, save_req}, 2'b10);
        tick();
        bus_idle();
        repeat (14) tick();
        chk("t5_race_early", 32'(save_req), 32'd0);
        tick();
        chk("t5_race_req", 32'(save_req), 32'd1);
        drain();

        // Soft bus reset
        push(1'b1, 24'h104040, 8'h78);
        bus_write(16'h4040, 8'h78);
        wait_req("t6_req");
        bus.RESET_n = 1'b0;
        repeat (2) tick();
        bus.RESET_n = 1'b1;
        repeat (2) tick();
        chk("t6_soft", {unlocked, dirty, save_req}, 3'b011);
        bus_write(16'h5FFE, 8'h4D);
        bus_write(16'h5FFF, 8'h69);
        push(1'b1, 24'h100002, 8'h9A);
        bus_write(16'h4002, 8'h9A);
        push(1'b1, 24'h100050, 8'hBC);
        start_write(16'h4050, 8'hBC);
        tick();
        chk("t6_we_low", 32'(ram.WE_n), 32'd0);
        bus.RESET_n = 1'b0;
        tick();
        chk("t6_mid_we", {ram.WE_n, ram.OE_n, ram.ADDR, ram.DIN}, {2'b11, 40'd0});
        chk("t6_mid_bus", {bus.DOUT, bus.BUSDIR_n}, 9'h001);
        tick();
        chk("t6_mid_flags", {unlocked, dirty, save_req}, 3'b011);
        bus_idle();
        tick();
        bus.RESET_n = 1'b1;
        repeat (4) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
